// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the CPU: instruction/data memories, sequential program loader,
// and a run controller that releases/starts the CPU and watches for HALT or timeout.
module cpu_mem_responder #(
  parameter int         ADDR_W     = 8,
  parameter int         DATA_W     = 16,
  parameter logic [4:0] HALT_OP    = 5'b00001,
  parameter int         MAX_CYCLES = 1024
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_datain,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_dataout,
  input  logic              d_we,
  output logic [DATA_W-1:0] d_datain,
  output logic              cpu_reset,
  output logic              cpu_enable,
  output logic              cpu_start,
  output logic              halted,
  output logic              timeout,
  output logic              ld_err,
  output logic [15:0]       cycles
);

  localparam int                DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [15:0]       TO_CNT   = 16'(MAX_CYCLES - 1);

  typedef enum logic [2:0] {
    S_LOAD,
    S_RELEASE,
    S_START,
    S_RUN,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [15:0]       cycles_q, cycles_d;
  logic              halted_q, halted_d;
  logic              timeout_q, timeout_d;
  logic              ld_err_q, ld_err_d;

  logic [DATA_W-1:0] imem [DEPTH];
  logic [DATA_W-1:0] dmem [DEPTH];

  logic              ld_xfer;
  logic              dmem_we;
  logic              halt_hit;
  logic              to_hit;
  logic [15:0]       cycles_inc;
  logic [DATA_W-1:0] imem_rd;

  // Memories carry no reset: their contents survive a reset of the controller.
  always_ff @(posedge clock) begin
    if (ld_xfer) begin
      imem[ptr_q] <= ld_data;
    end
    if (dmem_we) begin
      dmem[d_addr] <= d_dataout;
    end
  end

  assign ld_xfer = (state_q == S_LOAD) && ld_valid;
  assign dmem_we = (state_q == S_RUN) && d_we;

  // Zero-latency reads; the CPU sees NOPs until it has been released and started.
  assign imem_rd  = imem[i_addr];
  assign i_datain = ((state_q == S_LOAD) || (state_q == S_RELEASE)) ? '0 : imem_rd;
  assign d_datain = dmem[d_addr];

  assign halt_hit   = (state_q == S_RUN) && (i_datain[15:11] == HALT_OP);
  assign cycles_inc = (&cycles_q) ? cycles_q : (cycles_q + 16'd1);
  assign to_hit     = (state_q == S_RUN) && !halt_hit && (cycles_inc == TO_CNT);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_LOAD;
      ptr_q     <= '0;
      cycles_q  <= '0;
      halted_q  <= 1'b0;
      timeout_q <= 1'b0;
      ld_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cycles_q  <= cycles_d;
      halted_q  <= halted_d;
      timeout_q <= timeout_d;
      ld_err_q  <= ld_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cycles_d   = cycles_q;
    halted_d   = halted_q;
    timeout_d  = timeout_q;
    ld_err_d   = ld_err_q;
    ld_ready   = 1'b0;
    cpu_reset  = 1'b0;
    cpu_enable = 1'b0;
    cpu_start  = 1'b0;

    case (state_q)
      S_LOAD: begin
        ld_ready = 1'b1;
        if (ld_valid) begin
          ptr_d = ptr_q + 1'b1;
          if (ld_last) begin
            state_d = S_RELEASE;
          end else if (ptr_q == PTR_LAST) begin
            // Memory full without a last marker: flag it and run what was loaded.
            ld_err_d = 1'b1;
            state_d  = S_RELEASE;
          end
        end
      end
      S_RELEASE: begin
        cpu_reset  = 1'b1;
        cpu_enable = 1'b1;
        state_d    = S_START;
      end
      S_START: begin
        cpu_reset  = 1'b1;
        cpu_enable = 1'b1;
        cpu_start  = 1'b1;
        state_d    = S_RUN;
      end
      S_RUN: begin
        cpu_reset  = 1'b1;
        cpu_enable = 1'b1;
        cycles_d   = cycles_inc;
        if (halt_hit) begin
          halted_d = 1'b1;
          state_d  = S_DONE;
        end else if (to_hit) begin
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        cpu_reset = 1'b1;
      end
      default: begin
        state_d = S_LOAD;
      end
    endcase
  end

  assign halted  = halted_q;
  assign timeout = timeout_q;
  assign ld_err  = ld_err_q;
  assign cycles  = cycles_q;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed bench for cpu_mem_responder; the bench itself plays the CPU by driving i_addr/d_*.
module tb_cpu_mem_responder;

  logic        clock;
  logic        reset;
  logic        ld_valid;
  logic [15:0] ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic [7:0]  i_addr;
  logic [15:0] i_datain;
  logic [7:0]  d_addr;
  logic [15:0] d_dataout;
  logic        d_we;
  logic [15:0] d_datain;
  logic        cpu_reset;
  logic        cpu_enable;
  logic        cpu_start;
  logic        halted;
  logic        timeout;
  logic        ld_err;
  logic [15:0] cycles;

  int tests = 0;
  int fails = 0;

  cpu_mem_responder #(
    .ADDR_W    (8),
    .DATA_W    (16),
    .HALT_OP   (5'b00001),
    .MAX_CYCLES(20)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_last   (ld_last),
    .ld_ready  (ld_ready),
    .i_addr    (i_addr),
    .i_datain  (i_datain),
    .d_addr    (d_addr),
    .d_dataout (d_dataout),
    .d_we      (d_we),
    .d_datain  (d_datain),
    .cpu_reset (cpu_reset),
    .cpu_enable(cpu_enable),
    .cpu_start (cpu_start),
    .halted    (halted),
    .timeout   (timeout),
    .ld_err    (ld_err),
    .cycles    (cycles)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_word(input logic [15:0] w, input logic last);
    ld_valid = 1'b1;
    ld_data  = w;
    ld_last  = last;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    logic all_ready;
    reset = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
    i_addr = '0; d_addr = '0; d_dataout = '0; d_we = 1'b0;
    tick(); tick();
    check("rst_cpu_reset_held", cpu_reset, 0);
    reset = 1'b1;
    tick();

    // Reset state
    check("rst_ld_ready", ld_ready, 1);
    check("rst_cpu_enable", cpu_enable, 0);
    check("rst_cpu_start", cpu_start, 0);
    check("rst_flags", {halted, timeout, ld_err}, 0);
    check("rst_cycles", cycles, 0);
    check("rst_i_datain_nop", i_datain, 0);

    // Three-word program ending in HALT
    check("t1_ready0", ld_ready, 1); load_word(16'h1234, 1'b0);
    check("t1_ready1", ld_ready, 1); load_word(16'h0000, 1'b0);
    check("t1_ready2", ld_ready, 1); load_word(16'h0800, 1'b1);
    check("t1_rel_cpu_reset", cpu_reset, 1);
    check("t1_rel_cpu_enable", cpu_enable, 1);
    check("t1_rel_start", cpu_start, 0);
    check("t1_rel_ready", ld_ready, 0);
    check("t1_rel_nop", i_datain, 0);
    tick();
    check("t1_start_pulse", cpu_start, 1);
    check("t1_start_fetch", i_datain, 16'h1234);
    tick();
    check("t1_run_start_low", cpu_start, 0);
    check("t1_run_cycles0", cycles, 0);
    i_addr = 8'd0; tick();
    i_addr = 8'd1; tick();
    check("t1_run_cycles2", cycles, 2);
    i_addr = 8'd2; #1;
    check("t1_halt_fetch", i_datain, 16'h0800);
    check("t1_not_halted_yet", halted, 0);
    tick();
    check("t1_halted", halted, 1);
    check("t1_cycles3", cycles, 3);
    check("t1_done_enable", cpu_enable, 0);
    check("t1_done_reset", cpu_reset, 1);
    check("t1_no_timeout", timeout, 0);
    tick();
    check("t1_cycles_frozen", cycles, 3);

    // Store then load back
    do_reset();
    load_word(16'h1234, 1'b0);
    load_word(16'h2345, 1'b0);
    load_word(16'h0800, 1'b1);
    tick(); tick();
    i_addr = 8'd0; d_addr = 8'h10; d_dataout = 16'h00AA; d_we = 1'b1;
    tick();
    i_addr = 8'd1; d_dataout = 16'h0002; #1;
    check("t2_old_value_before_edge", d_datain, 16'h00AA);
    tick();
    d_we = 1'b0; #1;
    check("t2_readback", d_datain, 16'h0002);
    i_addr = 8'd2;
    tick();
    check("t2_halted", halted, 1);
    d_we = 1'b1; d_dataout = 16'hFFFF;
    tick();
    d_we = 1'b0; #1;
    check("t2_we_ignored_done", d_datain, 16'h0002);

    // Loop without HALT reaches the limit
    do_reset();
    load_word(16'h1234, 1'b0);
    load_word(16'h0000, 1'b1);
    tick(); tick();
    i_addr = 8'd0;
    repeat (18) tick();
    check("t3_cycles18", cycles, 18);
    check("t3_no_timeout_yet", timeout, 0);
    tick();
    check("t3_timeout", timeout, 1);
    check("t3_cycles19", cycles, 19);
    check("t3_not_halted", halted, 0);
    check("t3_done_enable", cpu_enable, 0);
    tick();
    check("t3_cycles_frozen", cycles, 19);

    // HALT on the same edge as the limit
    do_reset();
    load_word(16'h1234, 1'b0);
    load_word(16'h0000, 1'b0);
    load_word(16'h0800, 1'b1);
    tick(); tick();
    i_addr = 8'd0;
    repeat (18) tick();
    i_addr = 8'd2;
    tick();
    check("t3b_halt_wins", halted, 1);
    check("t3b_no_timeout", timeout, 0);
    check("t3b_cycles19", cycles, 19);

    // Overflow: 256 words, no last marker
    do_reset();
    all_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      ld_valid = 1'b1; ld_data = 16'(i); ld_last = 1'b0;
      if (ld_ready !== 1'b1) all_ready = 1'b0;
      tick();
    end
    ld_valid = 1'b0;
    check("t4_ready_all_256", all_ready, 1);
    check("t4_ld_err", ld_err, 1);
    check("t4_ld_ready_low", ld_ready, 0);
    check("t4_cpu_released", cpu_reset, 1);
    check("t4_no_start_yet", cpu_start, 0);
    tick();
    check("t4_started", cpu_start, 1);
    i_addr = 8'hFF; #1;
    check("t4_last_word", i_datain, 16'h00FF);
    tick();

    // Loader held valid during RUN must not touch imem
    i_addr = 8'd0;
    ld_valid = 1'b1; ld_data = 16'hFFFF; ld_last = 1'b1;
    repeat (5) tick();
    check("t6_ready_low_run", ld_ready, 0);
    check("t6_cycles5", cycles, 5);
    check("t6_imem0", i_datain, 16'h0000);
    i_addr = 8'd3; #1;
    check("t6_imem3", i_datain, 16'h0003);
    i_addr = 8'd4; #1;
    check("t6_imem4", i_datain, 16'h0004);
    ld_valid = 1'b0; ld_last = 1'b0;

    // Asynchronous reset mid-RUN
    #1;
    reset = 1'b0; #1;
    check("t5_cpu_reset", cpu_reset, 0);
    check("t5_cpu_enable", cpu_enable, 0);
    check("t5_cycles", cycles, 0);
    check("t5_flags", {halted, timeout, ld_err}, 0);
    check("t5_ld_ready", ld_ready, 1);
    tick();
    reset = 1'b1;
    load_word(16'hAAAA, 1'b0);
    load_word(16'h5555, 1'b0);
    load_word(16'h0800, 1'b1);
    tick();
    i_addr = 8'd0; #1;
    check("t5_new_word0", i_datain, 16'hAAAA);
    i_addr = 8'd1; #1;
    check("t5_new_word1", i_datain, 16'h5555);
    i_addr = 8'd3; #1;
    check("t5_old_word3", i_datain, 16'h0003);
    d_addr = 8'h10; #1;
    check("t5_dmem_kept", d_datain, 16'h0002);
    tick();
    i_addr = 8'd2;
    tick();
    check("t5_rerun_halted", halted, 1);
    check("t5_rerun_cycles", cycles, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
